test_pattern_checker: RTL and testbench
=======================================

# test_pattern_checker

Parametrised checker for the FPGA Test Mode data stream received over NWire into Mercury. It validates each `rdy`-qualified 32-bit word against the counting pattern {hi, hi+1} and can acquire lock mid-stream, not only at the first word. Lock is declared only after a configurable run of consecutive good words. It keeps saturating error and lock-loss counters for status readback, and its `tmc_err` output drives the LED flash-code logic.

## Interface
- `HALF_W`, 16: width of each half-word; data word is 2*HALF_W.
- `CNT_W`, 8: significant low bits per half; upper HALF_W-CNT_W bits must be zero.
- `FIRST`, 1: first sequence value.
- `STEP`, 4: increment between words.
- `LAST`, 253: final value before wrap to FIRST; (LAST-FIRST)%STEP==0 and LAST+1 < 2**CNT_W (elaboration-time check).
- `LOCK_COUNT`, 4: consecutive good words needed to lock (>=1).
- `ERRCNT_W`, 16: width of counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset `rst`, synchronous, active-high; clock `clk`.
- `data`  in  2*HALF_W  received word.
- `rdy`  in  1  `data` valid this cycle.
- `clr_cnt`  in  1  synchronous clear of `err_cnt` and `loss_cnt`.
- `locked`  out  1  pattern locked.
- `tmc_err`  out  1  equals ~`locked`.
- `err_cnt`  out  ERRCNT_W  mismatched words seen while in VERIFY or LOCKED; saturating.
- `loss_cnt`  out  ERRCNT_W  LOCKED->SEARCH transitions; saturating.

## Operation
- Member set S = {FIRST + k*STEP ≤ LAST}.
- Successor: next(x) = FIRST if x==LAST, else x+STEP.
- Word is well-formed when:
  - both upper pad fields are zero;
  - hi ∈ S;
  - lo == hi+1.
- States:
  - SEARCH: on `rdy` with a well-formed word, set exp=next(hi) and good=1. Go to LOCKED if LOCK_COUNT==1, else VERIFY. Malformed words are ignored; no count.
  - VERIFY: on `rdy`, word == {0,exp,0,exp+1} -> exp=next(exp), good+1; good reaching LOCK_COUNT -> LOCKED. Mismatch -> SEARCH, `err_cnt`+1.
  - LOCKED: on `rdy`, match -> exp=next(exp). Mismatch -> SEARCH, `err_cnt`+1, `loss_cnt`+1.
- Mismatch words never re-seed in the same cycle; the next `rdy` word is evaluated in SEARCH.
- `exp` advances only on `rdy`; cycles without `rdy` hold all state. Wrap happens on the accepted LAST word, never spontaneously.
- Counters saturate at all-ones. `clr_cnt` wins over a simultaneous increment (result 0).
- Reset values: state SEARCH, `locked`=0, `tmc_err`=1, `err_cnt`=0, `loss_cnt`=0, good=0, exp=FIRST.
- `rst` mid-operation returns to SEARCH on the next edge regardless of `rdy`.

## Timing
- All outputs are registered. The word sampled at edge N is reflected in state and outputs after edge N.
- Lock latency: `locked` rises after the edge that samples the LOCK_COUNT-th consecutive good word.
- Loss latency: `locked` falls and counters update after the edge that samples the bad word (one cycle).
- No backpressure. `rdy` may be asserted every cycle or sparsely; behaviour is identical apart from throughput.

## Structure
- Package `test_pattern_pkg`:
  - state enum (SEARCH, VERIFY, LOCKED);
  - functions `next_seq` and `is_member` parametrised by FIRST/STEP/LAST;
  - sat-increment helper.
- Sub-module `pattern_word_check` (combinational): outputs `well_formed`, `match_exp` and extracted `hi` for a given `exp`. The top holds the FSM, exp/good registers and counters.

## Test plan
- Reset, then 0x00010002, 0x00050006, 0x0009000A, 0x000D000E back-to-back -> `locked`=1 after the 4th edge; `tmc_err`=0; `err_cnt`=0.
- Locked stream through 0x00F900FA, 0x00FD00FE, 0x00010002 -> wrap accepted, `locked` stays 1.
- While locked, inject 0x00110013 in place of 0x00110012 -> `locked`=0 next cycle, `err_cnt`=1, `loss_cnt`=1. The stream resumes with 0x00150016, then three more good words -> relock after the 4th good word.
- Mid-stream start at 0x00410042 with `rdy` toggled every other cycle -> locks after 4 good words; idle cycles do not advance exp.
- Malformed words 0x01010102 and 0x00020003 in SEARCH -> ignored, `err_cnt` unchanged. Force `err_cnt` to 0xFFFF plus another mismatch -> stays 0xFFFF. `clr_cnt` coincident with a mismatch -> 0.
- `rst` asserted while LOCKED for one cycle -> SEARCH, `locked`=0, counters 0, exp=FIRST.

Source files
------------

// File: rtl/test_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pattern_pkg
// Description : Shared types and helpers for the NWire test-mode pattern
//               checker: FSM state encoding, counting-sequence helpers and
//               a saturating increment.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package test_pattern_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Successor in the counting sequence; wraps from last back to first.
  function automatic int unsigned next_seq(input int unsigned x,
                                           input int unsigned first,
                                           input int unsigned step,
                                           input int unsigned last);
    return (x == last) ? first : x + step;
  endfunction

  // True when x is one of first, first+step, ... , last.
  function automatic logic is_member(input int unsigned x,
                                     input int unsigned first,
                                     input int unsigned step,
                                     input int unsigned last);
    return (x >= first) && (x <= last) && (((x - first) % step) == 0);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input int unsigned w);
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= max_v) return v;
    return v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_word_check.sv
`default_nettype none
// ============================================================================
// Module      : pattern_word_check
// Description : Combinational decode of one received word {pad,hi,pad,lo}.
//               well_formed: pads zero, hi in the sequence, lo == hi+1.
//               match_exp  : word equals {0,exp,0,exp+1}.
// Ports       : data        in   2*HALF_W  received word
//               exp         in   CNT_W     expected sequence value
//               well_formed out  1
//               match_exp   out  1
//               hi          out  CNT_W     extracted high count
// Revision    : 1.0  initial release
// ============================================================================
module pattern_word_check
  import test_pattern_pkg::*;
#(
  parameter int unsigned HALF_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned FIRST  = 1,
  parameter int unsigned STEP   = 4,
  parameter int unsigned LAST   = 253
) (
  input  logic [2*HALF_W-1:0] data,
  input  logic [CNT_W-1:0]    exp,
  output logic                well_formed,
  output logic                match_exp,
  output logic [CNT_W-1:0]    hi
);

  logic [CNT_W-1:0] w_lo;
  logic             w_pads_zero;

  assign hi   = data[HALF_W+CNT_W-1:HALF_W];
  assign w_lo = data[CNT_W-1:0];

  generate
    if (HALF_W > CNT_W) begin : g_pad
      assign w_pads_zero = (data[2*HALF_W-1:HALF_W+CNT_W] == '0) &&
                           (data[HALF_W-1:CNT_W] == '0);
    end else begin : g_no_pad
      assign w_pads_zero = 1'b1;
    end
  endgenerate

  // Compare in CNT_W+1 bits so hi+1 never wraps into a false match.
  assign well_formed = w_pads_zero &&
                       is_member(32'(hi), FIRST, STEP, LAST) &&
                       ({1'b0, w_lo} == ({1'b0, hi} + 1'b1));

  assign match_exp   = w_pads_zero && (hi == exp) &&
                       ({1'b0, w_lo} == ({1'b0, exp} + 1'b1));

endmodule
`default_nettype wire

// File: rtl/test_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : test_pattern_checker
// Description : Lock/verify FSM for the FPGA test-mode counting stream.
//               Acquires on any well-formed word, locks after LOCK_COUNT
//               consecutive good words, counts mismatches and lock losses.
// Ports       : clk       in   1         clock
//               rst       in   1         synchronous active-high reset
//               data      in   2*HALF_W  received word
//               rdy       in   1         data valid this cycle
//               clr_cnt   in   1         clear err_cnt / loss_cnt
//               locked    out  1         pattern locked
//               tmc_err   out  1         ~locked, feeds LED flash code
//               err_cnt   out  ERRCNT_W  mismatches in VERIFY/LOCKED (sat)
//               loss_cnt  out  ERRCNT_W  LOCKED->SEARCH transitions (sat)
// Revision    : 1.0  initial release
// ============================================================================
module test_pattern_checker
  import test_pattern_pkg::*;
#(
  parameter int unsigned HALF_W     = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIRST      = 1,
  parameter int unsigned STEP       = 4,
  parameter int unsigned LAST       = 253,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERRCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*HALF_W-1:0] data,
  input  logic                rdy,
  input  logic                clr_cnt,
  output logic                locked,
  output logic                tmc_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ERRCNT_W-1:0] loss_cnt
);

  localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  generate
    if (!((LOCK_COUNT >= 1) && (STEP >= 1) && (LAST >= FIRST) &&
          (((LAST - FIRST) % STEP) == 0) && (CNT_W <= HALF_W) &&
          (ERRCNT_W >= 1) && (ERRCNT_W <= 32) &&
          ((64'(LAST) + 64'd1) < (64'd1 << CNT_W)))) begin : g_bad_params
      $error("test_pattern_checker: illegal parameter combination");
    end
  endgenerate

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_exp, w_exp_nxt;
  logic [GOOD_W-1:0]   r_good, w_good_nxt;
  logic                r_locked, r_tmc_err;
  logic [ERRCNT_W-1:0] r_err_cnt, r_loss_cnt;
  logic                w_err_inc, w_loss_inc;

  logic                w_well_formed, w_match_exp;
  logic [CNT_W-1:0]    w_hi;

  pattern_word_check #(
    .HALF_W (HALF_W),
    .CNT_W  (CNT_W),
    .FIRST  (FIRST),
    .STEP   (STEP),
    .LAST   (LAST)
  ) u_word_check (
    .data        (data),
    .exp         (r_exp),
    .well_formed (w_well_formed),
    .match_exp   (w_match_exp),
    .hi          (w_hi)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_good_nxt  = r_good;
    w_err_inc   = 1'b0;
    w_loss_inc  = 1'b0;
    if (rdy) begin
      case (r_state)
        ST_SEARCH: begin
          // Seed from the received value; malformed words are ignored.
          if (w_well_formed) begin
            w_exp_nxt   = CNT_W'(next_seq(32'(w_hi), FIRST, STEP, LAST));
            w_good_nxt  = GOOD_W'(1);
            w_state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_match_exp) begin
            w_exp_nxt  = CNT_W'(next_seq(32'(r_exp), FIRST, STEP, LAST));
            w_good_nxt = r_good + 1'b1;
            if ((32'(r_good) + 32'd1) == LOCK_COUNT) w_state_nxt = ST_LOCKED;
          end else begin
            // A mismatch never re-seeds; the next word is judged in SEARCH.
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_err_inc   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_match_exp) begin
            w_exp_nxt = CNT_W'(next_seq(32'(r_exp), FIRST, STEP, LAST));
          end else begin
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_err_inc   = 1'b1;
            w_loss_inc  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SEARCH;
      r_exp      <= CNT_W'(FIRST);
      r_good     <= '0;
      r_locked   <= 1'b0;
      r_tmc_err  <= 1'b1;
      r_err_cnt  <= '0;
      r_loss_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp     <= w_exp_nxt;
      r_good    <= w_good_nxt;
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_tmc_err <= (w_state_nxt != ST_LOCKED);
      // Clear takes priority over a same-cycle increment.
      if (clr_cnt) begin
        r_err_cnt  <= '0;
        r_loss_cnt <= '0;
      end else begin
        if (w_err_inc)  r_err_cnt  <= ERRCNT_W'(sat_inc(32'(r_err_cnt), ERRCNT_W));
        if (w_loss_inc) r_loss_cnt <= ERRCNT_W'(sat_inc(32'(r_loss_cnt), ERRCNT_W));
      end
    end
  end

  assign locked   = r_locked;
  assign tmc_err  = r_tmc_err;
  assign err_cnt  = r_err_cnt;
  assign loss_cnt = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_pattern_checker
// Description : Self-checking bench for test_pattern_checker. Instance "a"
//               uses default parameters; instance "b" uses LOCK_COUNT=1 and
//               3-bit counters so saturation is reached quickly.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_test_pattern_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        rdy = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        a_locked, a_tmc_err;
  logic [15:0] a_err_cnt, a_loss_cnt;
  logic        b_locked, b_tmc_err;
  logic [2:0]  b_err_cnt, b_loss_cnt;

  always #5 clk = ~clk;

  test_pattern_checker dut_a (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .rdy      (rdy),
    .clr_cnt  (clr_cnt),
    .locked   (a_locked),
    .tmc_err  (a_tmc_err),
    .err_cnt  (a_err_cnt),
    .loss_cnt (a_loss_cnt)
  );

  test_pattern_checker #(.LOCK_COUNT(1), .ERRCNT_W(3)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .rdy      (rdy),
    .clr_cnt  (clr_cnt),
    .locked   (b_locked),
    .tmc_err  (b_tmc_err),
    .err_cnt  (b_err_cnt),
    .loss_cnt (b_loss_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // ---------------- reference model ----------------
  // run = consecutive good words since acquisition (0 = searching).
  int m_run[2], m_exp[2], m_err[2], m_loss[2];
  int m_lock[2] = '{4, 1};
  int m_max[2]  = '{65535, 7};

  function automatic int nxt(input int v);
    return (v == 253) ? 1 : v + 4;
  endfunction

  function automatic logic [31:0] word(input int v);
    return {16'(v), 16'(v + 1)};
  endfunction

  function automatic bit well_formed(input logic [31:0] d);
    int hi, lo;
    hi = int'(d[31:16]);
    lo = int'(d[15:0]);
    return (hi >= 1) && (hi <= 253) && (((hi - 1) % 4) == 0) && (lo == hi + 1);
  endfunction

  task automatic model_step(input logic r, input logic v, input logic c, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      bit e_ev, l_ev;
      e_ev = 0;
      l_ev = 0;
      if (r) begin
        m_run[i] = 0; m_exp[i] = 1; m_err[i] = 0; m_loss[i] = 0;
      end else begin
        if (v) begin
          if (m_run[i] == 0) begin
            if (well_formed(d)) begin
              m_exp[i] = nxt(int'(d[31:16]));
              m_run[i] = 1;
            end
          end else if (d == word(m_exp[i])) begin
            m_exp[i] = nxt(m_exp[i]);
            if (m_run[i] < m_lock[i]) m_run[i]++;
          end else begin
            e_ev = 1;
            l_ev = (m_run[i] >= m_lock[i]);
            m_run[i] = 0;
          end
        end
        if (c) begin
          m_err[i] = 0; m_loss[i] = 0;
        end else begin
          if (e_ev && m_err[i] < m_max[i]) m_err[i]++;
          if (l_ev && m_loss[i] < m_max[i]) m_loss[i]++;
        end
      end
    end
  endtask

  task automatic check_b();
    bit lk;
    lk = (m_run[1] >= m_lock[1]);
    check("b_locked", 32'(b_locked), 32'(lk));
    check("b_tmc_err", 32'(b_tmc_err), 32'(!lk));
    check("b_err_cnt", 32'(b_err_cnt), 32'(m_err[1]));
    check("b_loss_cnt", 32'(b_loss_cnt), 32'(m_loss[1]));
  endtask

  task automatic check_a_model();
    bit lk;
    lk = (m_run[0] >= m_lock[0]);
    check("a_locked", 32'(a_locked), 32'(lk));
    check("a_tmc_err", 32'(a_tmc_err), 32'(!lk));
    check("a_err_cnt", 32'(a_err_cnt), 32'(m_err[0]));
    check("a_loss_cnt", 32'(a_loss_cnt), 32'(m_loss[0]));
  endtask

  // Drive one cycle, advance the model, and check instance b against it.
  task automatic cycle(input logic r, input logic v, input logic c, input logic [31:0] d);
    @(negedge clk);
    rst = r; rdy = v; clr_cnt = c; data = d;
    @(posedge clk);
    #1;
    model_step(r, v, c, d);
    check_b();
  endtask

  // ---------------- directed vectors for instance a ----------------
  typedef struct {
    logic        r, v, c;
    logic [31:0] d;
    logic        lk;
    logic [15:0] e, s;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic c, input logic [31:0] d,
                              input logic lk, input logic [15:0] e, input logic [15:0] s);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.d = d; t.lk = lk; t.e = e; t.s = s;
    return t;
  endfunction

  initial begin
    int g;
    // reset and initial lock
    tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h00010002, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h00050006, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0009000A, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h000D000E, 1, 0, 0));
    // loss while locked, then re-acquire
    tbl.push_back(mk(0, 1, 0, 32'h00110013, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00150016, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0019001A, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h001D001E, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00210022, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'hDEADBEEF, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00250026, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00290028, 0, 2, 2));
    // malformed words ignored in SEARCH
    tbl.push_back(mk(0, 1, 0, 32'h01010102, 0, 2, 2));
    tbl.push_back(mk(0, 1, 0, 32'h00020003, 0, 2, 2));
    // mid-stream acquisition with rdy every other cycle
    tbl.push_back(mk(0, 1, 0, 32'h00410042, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 32'h00450046, 0, 2, 2));
    tbl.push_back(mk(0, 1, 0, 32'h00450046, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 32'h0049004A, 0, 2, 2));
    tbl.push_back(mk(0, 1, 0, 32'h0049004A, 0, 2, 2));
    tbl.push_back(mk(0, 0, 0, 32'h004D004E, 0, 2, 2));
    tbl.push_back(mk(0, 1, 0, 32'h004D004E, 1, 2, 2));
    tbl.push_back(mk(0, 0, 0, 32'h00510052, 1, 2, 2));
    tbl.push_back(mk(0, 1, 0, 32'h00510052, 1, 2, 2));
    // reset while locked, with rdy and a good word present
    tbl.push_back(mk(1, 1, 0, 32'h00550056, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h00550056, 0, 0, 0));
    // clear coincident with a VERIFY mismatch
    tbl.push_back(mk(0, 1, 1, 32'h00590059, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h00010002, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h00000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h00000000, 0, 0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].d);
      check($sformatf("vec%0d_locked", i), 32'(a_locked), 32'(tbl[i].lk));
      check($sformatf("vec%0d_tmc_err", i), 32'(a_tmc_err), 32'(!tbl[i].lk));
      check($sformatf("vec%0d_err_cnt", i), 32'(a_err_cnt), 32'(tbl[i].e));
      check($sformatf("vec%0d_loss_cnt", i), 32'(a_loss_cnt), 32'(tbl[i].s));
    end

    // Full sequence through LAST and the wrap back to FIRST.
    cycle(1, 0, 0, 32'h0);
    g = 1;
    for (int k = 0; k < 66; k++) begin
      cycle(0, 1, 0, word(g));
      check($sformatf("wrap%0d_locked", k), 32'(a_locked), 32'(k >= 3));
      check($sformatf("wrap%0d_err_cnt", k), 32'(a_err_cnt), 32'd0);
      g = nxt(g);
    end

    // Randomized stream against the reference model for both instances.
    cycle(1, 0, 0, 32'h0);
    g = 1;
    for (int n = 0; n < 3000; n++) begin
      logic        v, c, r;
      logic [31:0] d;
      int          sel;
      v   = (($urandom % 4) != 0);
      c   = (($urandom % 64) == 0);
      r   = (($urandom % 700) == 0);
      sel = int'($urandom % 16);
      if (sel < 11) begin
        d = word(g);
        if (v) g = nxt(g);
      end else if (sel == 11) begin
        g = 1 + 4 * int'($urandom % 64);
        d = word(g);
        if (v) g = nxt(g);
      end else if (sel == 12) begin
        d = word(g) ^ (32'd1 << ($urandom % 32));
      end else if (sel == 13) begin
        d = $urandom;
      end else if (sel == 14) begin
        d = {16'(g), 16'(g + 2)};
      end else begin
        d = word(nxt(g));
      end
      cycle(r, v, c, d);
      check_a_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
